striping_n: RTL

- Parametrised successor to the two-lane byte striper.
- Distributes a single input word stream round-robin across LANES output lanes in the clk_2f domain, feeding the per-lane paths downstream.
- Adds: configurable width and lane count, a packed mode that skips invalid cycles, an align input that restarts the lane pointer, and a registered lane-pointer output for the unstriping side.

---
 rtl/striping_pkg.sv | 11 +
 rtl/striping_n_stripe_ptr.sv | 44 ++++
 rtl/striping_n.sv | 93 +++++++++
 3 files changed

// File: rtl/striping_pkg.sv
// striping_pkg: shared constants for the N-lane striper and its pointer.
//   STRIPE_DATA_W / STRIPE_LANES : default word width and lane count
//   MODE_LEGACY / MODE_PACKED    : pack_mode encoding
//   ROUND_CNT_W                  : width of the optional round counter
package striping_pkg;
  localparam int   STRIPE_DATA_W = 32;
  localparam int   STRIPE_LANES  = 4;
  localparam logic MODE_LEGACY   = 1'b0;
  localparam logic MODE_PACKED   = 1'b1;
  localparam int   ROUND_CNT_W   = 16;
endpackage

// File: rtl/striping_n_stripe_ptr.sv
// stripe_ptr: round-robin lane pointer shared by the striper and unstriper.
//   clk_2f    in  : clock, posedge
//   reset     in  : synchronous, active-high
//   align_in  in  : force this cycle's lane to 0
//   valid_in  in  : word present this cycle
//   pack_mode in  : MODE_LEGACY advances every cycle, MODE_PACKED only on valid
//   eff       out : lane used this cycle (combinational)
//   ptr       out : registered pointer, next lane to be written
module stripe_ptr
  import striping_pkg::*;
#(
  parameter int PTR_W = $clog2(STRIPE_LANES)
) (
  input  logic             clk_2f,
  input  logic             reset,
  input  logic             align_in,
  input  logic             valid_in,
  input  logic             pack_mode,
  output logic [PTR_W-1:0] eff,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] ptr_q, ptr_d;

  // Lane count is a power of two, so the +1 wraps LANES-1 -> 0 by overflow.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    eff   = align_in ? '0 : ptr_q;
    ptr_d = eff + PTR_W'(1);
    unique case (pack_mode)
      MODE_LEGACY: ptr_d = eff + PTR_W'(1);
      MODE_PACKED: ptr_d = valid_in ? eff + PTR_W'(1) : eff;
    endcase
  end

  always_ff @(posedge clk_2f) begin
    // NOTE: state registers use non-blocking assignment so all flops update together.
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/striping_n.sv
// striping_n: distributes one word stream round-robin over LANES lanes.
//   clk_2f    in  : clock, posedge
//   reset     in  : synchronous, active-high, discards any partial round
//   data_in   in  : input word
//   valid_in  in  : data_in qualifier
//   pack_mode in  : 0 legacy (pointer steps every cycle), 1 packed (steps on valid)
//   align_in  in  : send this cycle's word/slot to lane 0
//   lanes_out out : lane k at [k*DATA_W +: DATA_W]
//   valid_out out : per-lane valid
//   ptr_out   out : registered lane pointer
//   round_cnt out : (STRIPING_N_ROUND_CNT_EN only) count of words written to the last lane
module striping_n
  import striping_pkg::*;
#(
  parameter  int DATA_W = STRIPE_DATA_W,
  parameter  int LANES  = STRIPE_LANES,
  localparam int PTR_W  = $clog2(LANES)
) (
  input  logic                    clk_2f,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    valid_in,
  input  logic                    pack_mode,
  input  logic                    align_in,
  output logic [LANES*DATA_W-1:0] lanes_out,
  output logic [LANES-1:0]        valid_out,
  output logic [PTR_W-1:0]        ptr_out
`ifdef STRIPING_N_ROUND_CNT_EN
  ,
  output logic [ROUND_CNT_W-1:0]  round_cnt
`endif
);

  logic [PTR_W-1:0] eff;
  logic [PTR_W-1:0] ptr;

  stripe_ptr #(.PTR_W(PTR_W)) u_ptr (
    .clk_2f    (clk_2f),
    .reset     (reset),
    .align_in  (align_in),
    .valid_in  (valid_in),
    .pack_mode (pack_mode),
    .eff       (eff),
    .ptr       (ptr)
  );

  logic [LANES-1:0][DATA_W-1:0] lanes_q, lanes_d;
  logic [LANES-1:0]             valid_q, valid_d;

  // Only the effective lane changes; an empty slot clears its valid but keeps data.
  always_comb begin
    lanes_d      = lanes_q;
    valid_d      = valid_q;
    valid_d[eff] = valid_in;
    if (valid_in) lanes_d[eff] = data_in;
  end

  always_ff @(posedge clk_2f) begin
    // NOTE: lane storage is a plain register bank, reset to zero because the outputs must read 0 after reset.
    if (reset) begin
      lanes_q <= '0;
      valid_q <= '0;
    end else begin
      lanes_q <= lanes_d;
      valid_q <= valid_d;
    end
  end

  assign lanes_out = lanes_q;
  assign valid_out = valid_q;
  assign ptr_out   = ptr;

`ifdef STRIPING_N_ROUND_CNT_EN
  logic [ROUND_CNT_W-1:0] round_q, round_d;

  // Align restarts the round count and wins over a same-cycle increment.
  always_comb begin
    round_d = round_q;
    if (align_in)
      round_d = '0;
    else if (valid_in && eff == PTR_W'(LANES - 1))
      round_d = round_q + ROUND_CNT_W'(1);
  end

  always_ff @(posedge clk_2f) begin
    if (reset) round_q <= '0;
    else       round_q <= round_d;
  end

  assign round_cnt = round_q;
`endif

endmodule
